// File: rtl/vga_pkg.sv
// Shared VGA timing helpers: 640x480 defaults, derived totals and sync bounds.
package vga_pkg;

   localparam int DEF_H_ACTIVE   = 640;
   localparam int DEF_H_FP       = 16;
   localparam int DEF_H_SYNC     = 96;
   localparam int DEF_H_BP       = 48;
   localparam int DEF_V_ACTIVE   = 480;
   localparam int DEF_V_FP       = 10;
   localparam int DEF_V_SYNC     = 2;
   localparam int DEF_V_BP       = 33;
   localparam int DEF_COLOR_BITS = 4;

   typedef struct packed {
      logic [DEF_COLOR_BITS-1:0] r;
      logic [DEF_COLOR_BITS-1:0] g;
      logic [DEF_COLOR_BITS-1:0] b;
   } rgb_def_t;

   function automatic int line_total(input int act, input int fp,
                                     input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int sync_start(input int act, input int fp);
      return act + fp;
   endfunction

   function automatic int sync_end(input int act, input int fp,
                                   input int sync);
      return act + fp + sync;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Register chain of configurable width and depth with a synchronous reset value.
module vga_delay_line #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] rst_val_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   generate
      if (D == 0) begin : g_wire
         logic unused;
         assign unused = ^{clk_i, rst_i, rst_val_i};
         assign q_o    = d_i;
      end else begin : g_regs
         logic [W-1:0] stage_q [D];

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int i = 0; i < D; i++) stage_q[i] <= rst_val_i;
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < D; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[D-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// Raster timing with drawer-latency-aligned sync and blanked colour.
// Define VGA_TEST_PATTERN_EN to add the test_mode colour-bar input.
module vga_timing_pipe
   import vga_pkg::*;
#(
   parameter int H_ACTIVE     = DEF_H_ACTIVE,
   parameter int H_FP         = DEF_H_FP,
   parameter int H_SYNC       = DEF_H_SYNC,
   parameter int H_BP         = DEF_H_BP,
   parameter int V_ACTIVE     = DEF_V_ACTIVE,
   parameter int V_FP         = DEF_V_FP,
   parameter int V_SYNC       = DEF_V_SYNC,
   parameter int V_BP         = DEF_V_BP,
   parameter int H_POL        = 0,
   parameter int V_POL        = 0,
   parameter int COLOR_BITS   = DEF_COLOR_BITS,
   parameter int DRAW_LATENCY = 1,
   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int CW      = $clog2(H_TOTAL),
   localparam int RW      = $clog2(V_TOTAL)
) (
   input  logic                  vga_clock,
   input  logic                  reset,
   output logic [CW-1:0]         column,
   output logic [RW-1:0]         row,
   output logic                  draw_active,
   input  logic [COLOR_BITS-1:0] pix_red,
   input  logic [COLOR_BITS-1:0] pix_green,
   input  logic [COLOR_BITS-1:0] pix_blue,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                  test_mode,
`endif
   output logic                  hsync,
   output logic                  vsync,
   output logic [COLOR_BITS-1:0] vga_red,
   output logic [COLOR_BITS-1:0] vga_green,
   output logic [COLOR_BITS-1:0] vga_blue,
   output logic                  frame_start,
   output logic                  vblank_start
);

   generate
      if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
          V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
          DRAW_LATENCY < 0 || DRAW_LATENCY > 15) begin : g_bad_cfg
         $fatal(1, "vga_timing_pipe: illegal timing or latency parameter");
      end
   endgenerate

   typedef struct packed {
      logic [COLOR_BITS-1:0] r;
      logic [COLOR_BITS-1:0] g;
      logic [COLOR_BITS-1:0] b;
   } pix_t;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] HS_START = CW'(sync_start(H_ACTIVE, H_FP));
   localparam logic [CW-1:0] HS_END   = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
   localparam logic [RW-1:0] V_LAST   = RW'(V_TOTAL - 1);
   localparam logic [RW-1:0] V_ACT    = RW'(V_ACTIVE);
   localparam logic [RW-1:0] VS_START = RW'(sync_start(V_ACTIVE, V_FP));
   localparam logic [RW-1:0] VS_END   = RW'(sync_end(V_ACTIVE, V_FP, V_SYNC));
   localparam logic          HP       = (H_POL != 0);
   localparam logic          VP       = (V_POL != 0);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          hs_raw, vs_raw, de_raw;
   logic          hs_dly, vs_dly, de_dly;
   logic          hsync_q, vsync_q, fs_q, vb_q;
   pix_t          rgb_q, rgb_d;

   always_comb begin
      col_d = col_q + CW'(1);
      row_d = row_q;
      if (col_q == H_LAST) begin
         col_d = '0;
         row_d = (row_q == V_LAST) ? '0 : row_q + RW'(1);
      end
   end

   assign hs_raw = (col_q >= HS_START) && (col_q < HS_END);
   assign vs_raw = (row_q >= VS_START) && (row_q < VS_END);
   assign de_raw = (col_q < H_ACT) && (row_q < V_ACT);

   // Zero reset value = sync inactive, enable off: flushes stale contents.
   vga_delay_line #(.W(3), .D(DRAW_LATENCY)) u_sync_dly (
      .clk_i     (vga_clock),
      .rst_i     (reset),
      .rst_val_i (3'b000),
      .d_i       ({hs_raw, vs_raw, de_raw}),
      .q_o       ({hs_dly, vs_dly, de_dly})
   );

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

   logic [CW-1:0] dcol;
   logic [2:0]    bar;

   vga_delay_line #(.W(CW), .D(DRAW_LATENCY)) u_col_dly (
      .clk_i     (vga_clock),
      .rst_i     (reset),
      .rst_val_i ('0),
      .d_i       (col_q),
      .q_o       (dcol)
   );

   assign bar = 3'(dcol / CW'(BAR_W));
`endif

   always_comb begin
      rgb_d = '0;
      if (de_dly) begin
         rgb_d = {pix_red, pix_green, pix_blue};
`ifdef VGA_TEST_PATTERN_EN
         // Bars run W,Y,C,G,M,R,B,K: each channel is one bit of the bar index.
         if (test_mode) begin
            rgb_d.r = {COLOR_BITS{~bar[1]}};
            rgb_d.g = {COLOR_BITS{~bar[2]}};
            rgb_d.b = {COLOR_BITS{~bar[0]}};
         end
`endif
      end
   end

   always_ff @(posedge vga_clock) begin
      if (reset) begin
         col_q   <= '0;
         row_q   <= '0;
         hsync_q <= ~HP;
         vsync_q <= ~VP;
         rgb_q   <= '0;
         fs_q    <= 1'b0;
         vb_q    <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         hsync_q <= ~(hs_dly ^ HP);
         vsync_q <= ~(vs_dly ^ VP);
         rgb_q   <= rgb_d;
         fs_q    <= (col_q == '0) && (row_q == '0);
         vb_q    <= (col_q == '0) && (row_q == V_ACT);
      end
   end

   assign column       = col_q;
   assign row          = row_q;
   assign draw_active  = de_raw;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign vga_red      = rgb_q.r;
   assign vga_green    = rgb_q.g;
   assign vga_blue     = rgb_q.b;
   assign frame_start  = fs_q;
   assign vblank_start = vb_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Randomised bench for vga_timing_pipe against a frame-arithmetic reference.
module tb_vga_timing_pipe;

   localparam int HA = 16, HF = 2, HS = 4, HB = 2;
   localparam int VA = 6, VF = 2, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int LAT = 3;
   localparam int HPOL = 1, VPOL = 0;
   localparam int CB = 4;
   localparam int CW = $clog2(HT);
   localparam int RW = $clog2(VT);
   localparam int MAXN = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CB-1:0] pr = '0, pg = '0, pb = '0;
   logic [CW-1:0] column;
   logic [RW-1:0] row;
   logic          draw_active, hsync, vsync, frame_start, vblank_start;
   logic [CB-1:0] vr, vg, vb;
`ifdef VGA_TEST_PATTERN_EN
   logic          tm = 1'b0;
`endif

   int pix_hist [MAXN];
   bit tm_hist  [MAXN];
   int bars [8] = '{'hFFF, 'hFF0, 'h0FF, 'h0F0, 'hF0F, 'hF00, 'h00F, 'h000};
   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   vga_timing_pipe #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(HPOL), .V_POL(VPOL), .COLOR_BITS(CB), .DRAW_LATENCY(LAT)
   ) dut (
      .vga_clock    (clk),
      .reset        (rst),
      .column       (column),
      .row          (row),
      .draw_active  (draw_active),
      .pix_red      (pr),
      .pix_green    (pg),
      .pix_blue     (pb),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode    (tm),
`endif
      .hsync        (hsync),
      .vsync        (vsync),
      .vga_red      (vr),
      .vga_green    (vg),
      .vga_blue     (vb),
      .frame_start  (frame_start),
      .vblank_start (vblank_start)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Counter value n cycles after the reset edge is plain modular arithmetic.
   function automatic int mcol(input int n);
      return n % HT;
   endfunction

   function automatic int mrow(input int n);
      return (n / HT) % VT;
   endfunction

   function automatic int mact(input int n);
      return int'(mcol(n) < HA && mrow(n) < VA);
   endfunction

   function automatic int exp_rgb(input int n);
      int m;
      m = n - 1 - LAT;
      if (m < 0 || mact(m) == 0) return 0;
      if (tm_hist[n-1]) return bars[mcol(m) / (HA / 8)];
      return pix_hist[n-1];
   endfunction

   task automatic check_cycle(input int n);
      int m;
      bit hs, vs, fs, vbs;
      m   = n - 1 - LAT;
      hs  = m >= 0 && mcol(m) >= HA + HF && mcol(m) < HA + HF + HS;
      vs  = m >= 0 && mrow(m) >= VA + VF && mrow(m) < VA + VF + VS;
      fs  = n >= 1 && mcol(n-1) == 0 && mrow(n-1) == 0;
      vbs = n >= 1 && mcol(n-1) == 0 && mrow(n-1) == VA;
      check("column", 32'(column), 32'(mcol(n)));
      check("row", 32'(row), 32'(mrow(n)));
      check("draw_active", 32'(draw_active), 32'(mact(n)));
      check("hsync", 32'(hsync), 32'(hs ? HPOL : 1 - HPOL));
      check("vsync", 32'(vsync), 32'(vs ? VPOL : 1 - VPOL));
      check("rgb", 32'({vr, vg, vb}), 32'(exp_rgb(n)));
      check("frame_start", 32'(frame_start), 32'(fs));
      check("vblank_start", 32'(vblank_start), 32'(vbs));
   endtask

   task automatic drive(input int n);
      {pr, pg, pb} = 12'($urandom);
      pix_hist[n]  = int'({pr, pg, pb});
`ifdef VGA_TEST_PATTERN_EN
      tm          = ($urandom_range(0, 2) == 0);
      tm_hist[n]  = tm;
`else
      tm_hist[n]  = 1'b0;
`endif
   endtask

   task automatic run(input int ncyc);
      for (int n = 0; n < ncyc; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         check_cycle(n);
         drive(n);
      end
   endtask

   task automatic reset_dut(input int edges);
      rst = 1'b1;
      repeat (edges) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      reset_dut(3);
      run(3 * HT * VT + 40);
      reset_dut(1);
      run(HT * VT + 100 + int'($urandom_range(0, 50)));
      reset_dut(2);
      run(2 * HT * VT + int'($urandom_range(0, HT * VT - 1)));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
